// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, counter width and grant index sizing.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_e;

   localparam int CNT_W = 4;

   // A single requester still needs a 1-bit index.
   function automatic int gid_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search starting just after the pointer.
// Purely combinational.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GID_W   = gid_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   ptr,
   output logic [GID_W-1:0]   winner,
   output logic               any_valid
);

   // Walk from farthest to nearest so the nearest set bit wins.
   always_comb begin
      winner    = ptr;
      any_valid = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            winner    = GID_W'((int'(ptr) + k) % NUM_REQ);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among byte
// requesters; tracks tx_busy across each frame.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int  NUM_REQ      = 4,
   parameter int  DATA_W       = 8,
   parameter int  WR_CYCLES    = 2,
   parameter int  BUSY_TIMEOUT = 4,
   localparam int GID_W        = gid_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      uart_wr_o,
   output logic [DATA_W-1:0]         uart_dat_o,
   input  logic                      uart_tx_busy_i,
   output logic [GID_W-1:0]          grant_id,
   output logic                      active,
   output logic                      err_timeout
);

   arb_state_e state, state_n;

   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [GID_W-1:0]   ptr, ptr_n;
   logic [GID_W-1:0]   gid_n, win;
   logic [NUM_REQ-1:0] ready_n;
   logic [DATA_W-1:0]  dat_n;
   logic               any_valid;
   logic               wr_n, err_n;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .GID_W   (GID_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr),
      .winner    (win),
      .any_valid (any_valid)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ptr_n   = ptr;
      gid_n   = grant_id;
      dat_n   = uart_dat_o;
      ready_n = '0;
      wr_n    = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_valid && !uart_tx_busy_i) begin
               state_n      = ISSUE;
               cnt_n        = '0;
               ptr_n        = win;
               gid_n        = win;
               dat_n        = req_data[int'(win)*DATA_W +: DATA_W];
               ready_n[win] = 1'b1;
               wr_n         = 1'b1;
            end
         end
         ISSUE: begin
            if (cnt == CNT_W'(WR_CYCLES - 1)) begin
               state_n = WAIT_BUSY;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               wr_n  = 1'b1;
            end
         end
         WAIT_BUSY: begin
            // A byte that never raises busy is dropped, not retried.
            if (uart_tx_busy_i) begin
               state_n = WAIT_DONE;
            end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!uart_tx_busy_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ptr         <= GID_W'(NUM_REQ - 1);
         grant_id    <= '0;
         uart_dat_o  <= '0;
         req_ready   <= '0;
         uart_wr_o   <= 1'b0;
         err_timeout <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ptr         <= ptr_n;
         grant_id    <= gid_n;
         uart_dat_o  <= dat_n;
         req_ready   <= ready_n;
         uart_wr_o   <= wr_n;
         err_timeout <= err_n;
         active      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a UART
// busy model and a round-robin reference scoreboard.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int WRC   = 2;
   localparam int BTO   = 4;
   localparam int FRAME = 6;
   localparam int GW    = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            uart_wr_o;
   logic [DW-1:0]   uart_dat_o;
   logic            uart_tx_busy;
   logic [GW-1:0]   grant_id;
   logic            active;
   logic            err_timeout;

   logic busy_ext   = 1'b0;
   logic model_busy = 1'b0;
   logic uart_en    = 1'b1;
   logic prev_wr    = 1'b0;
   int   busy_cnt   = 0;

   logic [DW-1:0] rx_q[$];

   int tests_run    = 0;
   int tests_failed = 0;

   assign uart_tx_busy = busy_ext | model_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .DATA_W       (DW),
      .WR_CYCLES    (WRC),
      .BUSY_TIMEOUT (BTO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .uart_wr_o      (uart_wr_o),
      .uart_dat_o     (uart_dat_o),
      .uart_tx_busy_i (uart_tx_busy),
      .grant_id       (grant_id),
      .active         (active),
      .err_timeout    (err_timeout)
   );

   // UART model: latches a byte on the wr rising edge, then busy for FRAME clocks.
   always @(negedge clk) begin
      if (uart_en && uart_wr_o && !prev_wr) begin
         rx_q.push_back(uart_dat_o);
         busy_cnt = FRAME;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
      model_busy = (busy_cnt > 0);
      prev_wr    = uart_wr_o;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int c = 0; c < 200; c++) begin
         if (!active && !model_busy && !uart_wr_o) begin
            done = 1;
            break;
         end
         tick();
      end
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s idle: got busy/active, expected idle", tag);
      end
   endtask

   task automatic wait_ready(output logic [N-1:0] r, output int g);
      r = '0;
      g = -1;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (req_ready != '0) begin
            r = req_ready;
            g = int'(grant_id);
            break;
         end
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests_run += 6;
      if (req_ready !== '0) begin
         tests_failed++;
         $display("FAIL reset ready: got %b expected 0", req_ready);
      end
      if (uart_wr_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset wr: got %b expected 0", uart_wr_o);
      end
      if (uart_dat_o !== '0) begin
         tests_failed++;
         $display("FAIL reset dat: got %h expected 0", uart_dat_o);
      end
      if (grant_id !== '0) begin
         tests_failed++;
         $display("FAIL reset gid: got %0d expected 0", grant_id);
      end
      if (active !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset active: got %b expected 0", active);
      end
      if (err_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset err: got %b expected 0", err_timeout);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int rdy = 0;
      int wr = 0;
      int errs = 0;
      bit seen = 0;
      bit first_ok = 1;
      rx_q.delete();
      req_data[7:0] = 8'hAF;
      req_valid = 4'b0001;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (req_ready != '0) begin
            rdy++;
            if (req_ready !== 4'b0001 || uart_wr_o !== 1'b1)
               first_ok = 0;
            req_valid = '0;
         end
         if (uart_wr_o) wr++;
         if (err_timeout) errs++;
         if (active) seen = 1;
         if (seen && !active) break;
      end
      tests_run += 7;
      if (rdy !== 1) begin
         tests_failed++;
         $display("FAIL single ready_cnt: got %0d expected 1", rdy);
      end
      if (first_ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL single ready_shape: got bad expected 0001 with wr");
      end
      if (wr !== WRC) begin
         tests_failed++;
         $display("FAIL single wr_cnt: got %0d expected %0d", wr, WRC);
      end
      if (uart_dat_o !== 8'hAF) begin
         tests_failed++;
         $display("FAIL single dat: got %h expected af", uart_dat_o);
      end
      if (errs !== 0) begin
         tests_failed++;
         $display("FAIL single err: got %0d expected 0", errs);
      end
      if (!(seen && !active)) begin
         tests_failed++;
         $display("FAIL single idle: got %b expected 0", active);
      end
      if (rx_q.size() !== 1 || rx_q[0] !== 8'hAF) begin
         tests_failed++;
         $display("FAIL single rx: got %0d bytes expected 1 (af)", rx_q.size());
      end
      wait_idle("single");
   endtask

   task automatic test_contention();
      int exp_g[5];
      logic [7:0] exp_b[5];
      int n = 0;
      exp_g = '{0, 1, 2, 3, 0};
      exp_b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
      do_reset();
      wait_idle("cont_pre");
      rx_q.delete();
      req_data = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid = '1;
      for (int c = 0; c < 300 && n < 5; c++) begin
         tick();
         if (req_ready != '0) begin
            tests_run++;
            if (grant_id !== GW'(exp_g[n]) ||
                req_ready !== N'(1 << exp_g[n])) begin
               tests_failed++;
               $display("FAIL cont grant%0d: got %0d/%b expected %0d",
                        n, grant_id, req_ready, exp_g[n]);
            end
            n++;
            if (n == 5) req_valid = '0;
         end
      end
      tests_run++;
      if (n !== 5) begin
         tests_failed++;
         $display("FAIL cont count: got %0d expected 5", n);
      end
      wait_idle("cont");
      tests_run++;
      if (rx_q.size() !== 5) begin
         tests_failed++;
         $display("FAIL cont rx_size: got %0d expected 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (rx_q[i] !== exp_b[i]) begin
               tests_failed++;
               $display("FAIL cont rx%0d: got %h expected %h",
                        i, rx_q[i], exp_b[i]);
            end
         end
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] r;
      int g;
      req_valid = 4'b0010;
      wait_ready(r, g);
      req_valid = '0;
      tests_run++;
      if (r !== 4'b0010) begin
         tests_failed++;
         $display("FAIL fair setup: got %b expected 0010", r);
      end
      wait_idle("fair1");
      req_valid = 4'b1001;
      wait_ready(r, g);
      req_valid[3] = 1'b0;
      tests_run++;
      if (r !== 4'b1000 || g !== 3) begin
         tests_failed++;
         $display("FAIL fair first: got %b/%0d expected 1000/3", r, g);
      end
      wait_ready(r, g);
      req_valid = '0;
      tests_run++;
      if (r !== 4'b0001 || g !== 0) begin
         tests_failed++;
         $display("FAIL fair second: got %b/%0d expected 0001/0", r, g);
      end
      wait_idle("fair2");
   endtask

   task automatic test_timeout();
      logic [N-1:0] r;
      int g;
      int k_err = -1;
      int pulses = 0;
      rx_q.delete();
      uart_en = 1'b0;
      req_data[23:16] = 8'h5A;
      req_valid = 4'b0100;
      wait_ready(r, g);
      req_valid = '0;
      tests_run++;
      if (r !== 4'b0100) begin
         tests_failed++;
         $display("FAIL tmo grant: got %b expected 0100", r);
      end
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (err_timeout) begin
            pulses++;
            if (k_err < 0) k_err = c;
         end
      end
      tests_run += 3;
      if (pulses !== 1) begin
         tests_failed++;
         $display("FAIL tmo pulses: got %0d expected 1", pulses);
      end
      if (k_err !== WRC + BTO) begin
         tests_failed++;
         $display("FAIL tmo delay: got %0d expected %0d", k_err, WRC + BTO);
      end
      if (active !== 1'b0) begin
         tests_failed++;
         $display("FAIL tmo idle: got %b expected 0", active);
      end
      uart_en = 1'b1;
      req_data[23:16] = 8'hC3;
      req_valid = 4'b0100;
      wait_ready(r, g);
      req_valid = '0;
      tests_run++;
      if (r !== 4'b0100) begin
         tests_failed++;
         $display("FAIL tmo regrant: got %b expected 0100", r);
      end
      wait_idle("tmo");
      tests_run++;
      if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3) begin
         tests_failed++;
         $display("FAIL tmo rx: got %0d bytes expected 1 (c3)", rx_q.size());
      end
   endtask

   task automatic test_ext_busy();
      int bad = 0;
      busy_ext = 1'b1;
      req_data[15:8] = 8'h66;
      req_valid = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (req_ready != '0 || uart_wr_o) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL extbusy hold: got %0d grants expected 0", bad);
      end
      busy_ext = 1'b0;
      tick();
      tests_run++;
      if (req_ready !== 4'b0010) begin
         tests_failed++;
         $display("FAIL extbusy release: got %b expected 0010", req_ready);
      end
      req_valid = '0;
      wait_idle("extbusy");
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] r;
      int g;
      req_data[7:0] = 8'h77;
      req_valid = 4'b0001;
      wait_ready(r, g);
      req_valid = '0;
      tick();
      tests_run++;
      if (uart_wr_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid setup: got wr=%b expected 1", uart_wr_o);
      end
      rst = 1'b1;
      tick();
      tests_run += 4;
      if (uart_wr_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid wr: got %b expected 0", uart_wr_o);
      end
      if (active !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid active: got %b expected 0", active);
      end
      if (req_ready !== '0) begin
         tests_failed++;
         $display("FAIL rstmid ready: got %b expected 0", req_ready);
      end
      if (grant_id !== '0) begin
         tests_failed++;
         $display("FAIL rstmid gid: got %0d expected 0", grant_id);
      end
      rst = 1'b0;
      req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req_valid = '1;
      wait_ready(r, g);
      req_valid = '0;
      tests_run++;
      if (r !== 4'b0001) begin
         tests_failed++;
         $display("FAIL rstmid first: got %b expected 0001", r);
      end
      wait_idle("rstmid");
   endtask

   task automatic test_random();
      logic [DW-1:0] expq[$];
      int ptr_m = 0;
      int grants = 0;
      int errs = 0;
      int w;
      rx_q.delete();
      req_valid = '0;
      for (int c = 0; c < 2000 && grants < 40; c++) begin
         tick();
         if (err_timeout) errs++;
         if (req_ready != '0) begin
            w = -1;
            for (int j = 1; j <= N; j++)
               if (w < 0 && req_valid[(ptr_m + j) % N]) w = (ptr_m + j) % N;
            tests_run++;
            if (w < 0) begin
               tests_failed++;
               $display("FAIL rand grant: got %b expected none", req_ready);
            end else begin
               if (req_ready !== N'(1 << w) || grant_id !== GW'(w) ||
                   uart_dat_o !== req_data[w*DW +: DW]) begin
                  tests_failed++;
                  $display("FAIL rand grant: got %b/%0d/%h expected %0d/%h",
                           req_ready, grant_id, uart_dat_o, w,
                           req_data[w*DW +: DW]);
               end
               expq.push_back(req_data[w*DW +: DW]);
               ptr_m = w;
               req_valid[w] = 1'b0;
            end
            grants++;
         end
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(3) == 0) begin
               req_data[i*DW +: DW] = DW'($urandom);
               req_valid[i] = 1'b1;
            end
         end
      end
      req_valid = '0;
      tests_run += 2;
      if (grants !== 40) begin
         tests_failed++;
         $display("FAIL rand count: got %0d expected 40", grants);
      end
      if (errs !== 0) begin
         tests_failed++;
         $display("FAIL rand err: got %0d expected 0", errs);
      end
      wait_idle("rand");
      tests_run++;
      if (rx_q.size() !== expq.size()) begin
         tests_failed++;
         $display("FAIL rand rx_size: got %0d expected %0d",
                  rx_q.size(), expq.size());
      end else begin
         for (int i = 0; i < expq.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== expq[i]) begin
               tests_failed++;
               $display("FAIL rand rx%0d: got %h expected %h",
                        i, rx_q[i], expq[i]);
            end
         end
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_timeout();
      test_ext_busy();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
